// File: rtl/thread_scheduler_4way.sv
// Round-robin issue scheduler for a 4-thread fine-grained multithreaded core.
// Skips inactive, stalled, halting or cooling threads; outputs are registered.
module thread_scheduler_4way #(
  parameter int MIN_GAP = 4,
  parameter int CNT_W   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] thread_start,
  input  logic [3:0] thread_halt,
  input  logic [3:0] thread_stall,
  output logic       issue_valid,
  output logic [1:0] tid,
  output logic [3:0] active,
  output logic       all_idle
);

  logic [CNT_W-1:0] cool [4];
  logic [1:0]       last;
  logic [3:0]       elig;
  logic [1:0]       sel;
  logic [1:0]       cand;
  logic             found;
  logic             do_issue;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      elig[i] = active[i] & ~thread_stall[i] & ~thread_halt[i] & (cool[i] == '0);
    end
  end

  // Search starts one past the last issued thread and wraps around.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && elig[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign do_issue = en & found;
  assign all_idle = ~|active;

  always_ff @(posedge clk) begin
    if (!rst) begin
      active      <= '0;
      last        <= 2'd3;
      issue_valid <= 1'b0;
      tid         <= '0;
      for (int i = 0; i < 4; i++) cool[i] <= '0;
    end else begin
      issue_valid <= do_issue;
      if (do_issue) begin
        tid  <= sel;
        last <= sel;
      end
      // Start/halt clear the gap window; halt wins over a simultaneous start.
      for (int i = 0; i < 4; i++) begin
        if (thread_halt[i]) begin
          active[i] <= 1'b0;
          cool[i]   <= '0;
        end else if (thread_start[i]) begin
          active[i] <= 1'b1;
          cool[i]   <= '0;
        end else if (do_issue && sel == 2'(i)) begin
          cool[i] <= CNT_W'(MIN_GAP - 1);
        end else if (cool[i] != '0) begin
          cool[i] <= cool[i] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_thread_scheduler_4way.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-stamp reference model of the round-robin issue rules.
module tb_thread_scheduler_4way;

  localparam int MIN_GAP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] thread_start = '0;
  logic [3:0] thread_halt = '0;
  logic [3:0] thread_stall = '0;
  logic       issue_valid;
  logic [1:0] tid;
  logic [3:0] active;
  logic       all_idle;

  int checks = 0;
  int errors = 0;

  thread_scheduler_4way #(.MIN_GAP(MIN_GAP), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en),
    .thread_start(thread_start), .thread_halt(thread_halt), .thread_stall(thread_stall),
    .issue_valid(issue_valid), .tid(tid), .active(active), .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  // Reference model: per-thread cycle stamp of the most recent issue.
  logic [3:0] m_act = '0;
  int         m_last_iss [4] = '{-100, -100, -100, -100};
  int         m_ptr = 3;
  logic       m_valid = 1'b0;
  logic [1:0] m_tid = '0;
  int         cyc = 0;

  function automatic int model_sel(input logic [3:0] st, input logic [3:0] h);
    int s;
    s = -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (s < 0 && m_act[c] && !st[c] && !h[c] && (cyc - m_last_iss[c] >= MIN_GAP)) s = c;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] s,
                      input logic [3:0] h, input logic [3:0] st);
    int sel;
    rst = r; en = e; thread_start = s; thread_halt = h; thread_stall = st;
    if (!r) begin
      m_act = '0;
      for (int i = 0; i < 4; i++) m_last_iss[i] = -100;
      m_ptr = 3; m_valid = 1'b0; m_tid = '0;
    end else begin
      sel = model_sel(st, h);
      if (e && sel >= 0) begin
        m_valid = 1'b1; m_tid = 2'(sel); m_ptr = sel; m_last_iss[sel] = cyc;
      end else begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (h[i]) begin
          m_act[i] = 1'b0; m_last_iss[i] = -100;
        end else if (s[i]) begin
          m_act[i] = 1'b1; m_last_iss[i] = -100;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("issue_valid", {3'b0, issue_valid}, {3'b0, m_valid});
    chk("tid", {2'b0, tid}, {2'b0, m_tid});
    chk("active", active, m_act);
    chk("all_idle", {3'b0, all_idle}, {3'b0, (m_act == 4'b0)});
  endtask

  initial begin
    int guard;
    logic [3:0] rs, rh, rst_v;

    for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 4'h0, 4'h0);
    chk("reset_idle", {3'b0, all_idle}, 4'h1);

    // Single thread: issues every MIN_GAP cycles.
    step(1, 1, 4'b0001, 4'h0, 4'h0);
    chk("start_active", active, 4'b0001);
    for (int i = 0; i < 12; i++) step(1, 1, 4'h0, 4'h0, 4'h0);

    // All four threads: back-to-back round robin.
    step(1, 1, 4'b1110, 4'h0, 4'h0);
    for (int i = 0; i < 8; i++) step(1, 1, 4'h0, 4'h0, 4'h0);

    // Stall thread 2 for three cycles.
    for (int i = 0; i < 3; i++) step(1, 1, 4'h0, 4'h0, 4'b0100);
    for (int i = 0; i < 6; i++) step(1, 1, 4'h0, 4'h0, 4'h0);

    // Drop to threads 0/1, then halt thread 1 when it would be chosen.
    step(1, 1, 4'h0, 4'b1100, 4'h0);
    guard = 0;
    while (model_sel(4'h0, 4'h0) != 1 && guard < 10) begin
      step(1, 1, 4'h0, 4'h0, 4'h0);
      guard++;
    end
    chk("halt_target_reached", {3'b0, (guard < 10)}, 4'h1);
    step(1, 1, 4'h0, 4'b0010, 4'h0);
    chk("halt_active", active, 4'b0001);

    // Simultaneous start and halt: halt wins.
    step(1, 1, 4'b0100, 4'b0100, 4'h0);
    chk("start_halt_same", active, 4'b0001);

    // Two threads, issue enable off for five cycles.
    step(1, 1, 4'b0010, 4'h0, 4'h0);
    step(1, 1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) step(1, 1, 4'h0, 4'h0, 4'h0);

    // Reset mid-stream with a start pulse in the same cycle.
    step(0, 1, 4'b1111, 4'h0, 4'h0);
    chk("rst_active", active, 4'h0);
    chk("rst_valid", {3'b0, issue_valid}, 4'h0);
    chk("rst_tid", {2'b0, tid}, 4'h0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rs    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      rh    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      rst_v = 4'($urandom) & 4'($urandom);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0), rs, rh, rst_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thread_scheduler_4way.md
# thread_scheduler_4way

Issue scheduler for the 4-thread fine-grained multithreaded CPU. Each cycle it picks the next thread to fetch/issue by round-robin, skipping threads that are inactive, externally stalled, or still inside their per-thread issue-gap window. It sits in front of the fetch stage and provides the registered thread ID that steers the PC and register-file bank selection. Threads are activated and halted individually by start/halt pulses.

## Interface
- MIN_GAP, 4: minimum cycles between two issues of the same thread (pipeline-hazard spacing); legal range 1..8; 1 = back-to-back allowed
- CNT_W, 3: width of each per-thread gap counter; must hold MIN_GAP-1

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- en  in  1  global issue enable; 0 = no issue this cycle, all other state keeps updating
- thread_start  in  4  per-thread one-cycle pulse: activate thread i
- thread_halt  in  4  per-thread one-cycle pulse: deactivate thread i
- thread_stall  in  4  per-thread level: thread i is waiting (e.g. memory) and is not eligible
- issue_valid  out  1  registered; tid is a valid issue slot this cycle
- tid  out  2  registered; thread ID of the current issue slot
- active  out  4  registered per-thread active mask
- all_idle  out  1  combinational; 1 when active == 0

## Operation
- State: active[3:0], gap counter cool[i] (CNT_W bits) per thread, round-robin pointer last (2 bits), issue_valid, tid.
- Eligibility, evaluated on current-cycle values: elig[i] = active[i] & ~thread_stall[i] & ~thread_halt[i] & (cool[i] == 0).
- Selection: search from (last+1) mod 4 upward with wrap, first elig thread wins; at most one thread per cycle.
- At each edge, if en & |elig: issue_valid<=1, tid<=sel, last<=sel, cool[sel]<=MIN_GAP-1.
- Otherwise: issue_valid<=0; tid and last hold.
- Gap counters: every non-selected cool[i] != 0 decrements by 1 each cycle, regardless of en or stall; saturates at 0.
- Start: active[i]<=1, cool[i]<=0. Halt: active[i]<=0, cool[i]<=0. If start and halt are asserted together for the same thread, halt wins. Start on an already-active thread: no effect except clearing cool[i]. Halt on an inactive thread: no effect.
- A halt pulse blocks that thread's issue in the same cycle, so a halted thread never issues after its halt edge.
- Stall does not affect the pointer or the counters. A stalled thread is skipped and regains eligibility in the first cycle its stall is low.
- Reset (rst==0 at edge): active=0, cool=0, last=3 (first search starts at thread 0), issue_valid=0, tid=0; all_idle=1. Reset overrides all other inputs, including start pulses in the same cycle. Mid-operation reset drops any in-flight selection.

## Timing
- Outputs issue_valid and tid are registered, with a 1-cycle selection latency.
- thread_start at edge N: active visible after N. The earliest issue_valid is after edge N+1.
- A thread issued at edge E is next eligible to issue at edge E+MIN_GAP.
- With 4 active, unstalled threads and MIN_GAP<=4: tid sequence 0,1,2,3,0,… every cycle, with issue_valid continuously 1.
- Stall, halt and en act combinationally on the selection for the same edge, with no added latency.
- all_idle follows active with no extra register.

## Test plan
- Reset then start=4'b0001 at edge 0, en=1, MIN_GAP=4 -> issue_valid=1, tid=0 after edges 1,5,9,… and 0 after all other edges; active=4'b0001, all_idle=0.
- Start 4'b1111 together -> tid 0,1,2,3,0,1 on consecutive cycles; issue_valid never drops.
- All 4 active; thread_stall=4'b0100 for 3 cycles -> thread 2 is skipped (sequence …1,3,0,1,3…), then resumes in order with no pointer corruption.
- Active 4'b0011 with halt[1] pulsed on the cycle thread 1 would be selected -> thread 1 does not issue and thread 0 issues if eligible; active becomes 4'b0001. Start and halt both asserted on thread 2 -> active[2] stays 0.
- en=0 for 5 cycles with 2 threads active -> issue_valid=0, tid held, cool counters drain to 0. After en returns to 1, issue resumes at (last+1) on the next edge.
- Reset asserted mid-stream with a start pulse in the same cycle -> after the edge, active=0, issue_valid=0, tid=0, all_idle=1.
